// File: rtl/op_lut_defines.sv
// Shared definitions for the output-port-lookup forwarding stage:
// FSM state encoding and default IO-queue header constants.
package op_lut_defines;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDRS,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  localparam int unsigned IOQ_STAGE_NUM_DEF = 32'hff;
  localparam int unsigned DST_PORT_POS_DEF  = 0;

endpackage

// File: rtl/opl_mask_prune.sv
// Turns a raw lookup mask into the final destination mask by optionally
// clearing the ingress port bit; flags masks that end up empty.
module opl_mask_prune #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_IQ_BITS       = 3
) (
  input  logic [NUM_OUTPUT_QUEUES-1:0] i_raw_mask,
  input  logic [NUM_IQ_BITS-1:0]       i_src_port,
  input  logic                         i_prune_en,
  output logic [NUM_OUTPUT_QUEUES-1:0] o_final_mask,
  output logic                         o_mask_zero
);

  // NOTE: a combinational block assigns every output a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_final_mask = i_raw_mask;
    // An out-of-range src_port matches no bit and leaves the mask intact.
    for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      if (i_prune_en && (int'(i_src_port) == i)) o_final_mask[i] = 1'b0;
    end
  end

  assign o_mask_zero = (o_final_mask == '0);

endmodule

// File: rtl/small_fifo.sv
// Small synchronous FIFO with first-word fall-through output.
// Callers never write when full nor read when empty.
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty,
  input  logic             clk,
  input  logic             reset
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_V = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NFULL_V = DEPTH_V - 1'b1;

  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [MAX_DEPTH_BITS:0]   r_count;

  // NOTE: storage is deliberately left out of reset; only pointers and the
  // count need a defined value, and resetting the array would cost a reset
  // net per bit and prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout        = r_mem[r_rd_ptr];
  assign empty       = (r_count == '0);
  assign full        = (r_count == DEPTH_V);
  assign nearly_full = (r_count >= NFULL_V);

endmodule

// File: rtl/opl_learning_fwd_stage.sv
// Learning-switch forwarding stage: pairs buffered packets with lookup
// decisions, rewrites the IO-queue header port mask and drops empty-mask packets.
module opl_learning_fwd_stage
  import op_lut_defines::*;
#(
  parameter int                    DATA_WIDTH          = 64,
  parameter int                    CTRL_WIDTH          = DATA_WIDTH / 8,
  parameter int                    NUM_OUTPUT_QUEUES   = 8,
  parameter int                    NUM_IQ_BITS         = 3,
  parameter int                    PKT_FIFO_DEPTH_BITS = 4,
  parameter int                    DEC_FIFO_DEPTH_BITS = 2,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM       = CTRL_WIDTH'(IOQ_STAGE_NUM_DEF),
  parameter int unsigned           DST_PORT_POS        = DST_PORT_POS_DEF,
  parameter bit                    PRUNE_SRC_DEFAULT   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic                         lookup_valid,
  input  logic [NUM_OUTPUT_QUEUES-1:0] lookup_dst_ports,
  input  logic [NUM_IQ_BITS-1:0]       lookup_src_port,
  input  logic                         prune_en,
  output logic [31:0]                  pkt_fwd_cnt,
  output logic [31:0]                  pkt_drop_cnt,
  output logic                         dec_overflow
);

  localparam int PKT_W = DATA_WIDTH + CTRL_WIDTH;
  localparam int DEC_W = NUM_OUTPUT_QUEUES + NUM_IQ_BITS;

  state_t                       r_state;
  logic [NUM_OUTPUT_QUEUES-1:0] r_mask;
  logic                         r_drop_payload;
  logic [31:0]                  r_fwd_cnt;
  logic [31:0]                  r_drop_cnt;
  logic                         r_dec_ovf;

  logic [PKT_W-1:0]             w_pkt_dout;
  logic                         w_pkt_full, w_pkt_nfull, w_pkt_empty;
  logic                         w_pkt_wr, w_pkt_rd;
  logic [DATA_WIDTH-1:0]        w_head_data;
  logic [CTRL_WIDTH-1:0]        w_head_ctrl;
  logic [DEC_W-1:0]             w_dec_dout;
  logic                         w_dec_full, w_dec_nfull, w_dec_empty;
  logic                         w_dec_wr, w_dec_rd;
  logic [NUM_OUTPUT_QUEUES-1:0] w_final_mask;
  logic                         w_mask_zero;
  logic                         w_prune_en;
  logic                         w_fwd_state;
  logic [DATA_WIDTH-1:0]        w_out_data;

  assign w_pkt_wr = in_wr && !w_pkt_full;
  assign w_dec_wr = lookup_valid && !w_dec_full;

  small_fifo #(
    .WIDTH          (PKT_W),
    .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
  ) u_pkt_fifo (
    .din         ({in_ctrl, in_data}),
    .wr_en       (w_pkt_wr),
    .rd_en       (w_pkt_rd),
    .dout        (w_pkt_dout),
    .full        (w_pkt_full),
    .nearly_full (w_pkt_nfull),
    .empty       (w_pkt_empty),
    .clk         (clk),
    .reset       (reset)
  );

  small_fifo #(
    .WIDTH          (DEC_W),
    .MAX_DEPTH_BITS (DEC_FIFO_DEPTH_BITS)
  ) u_dec_fifo (
    .din         ({lookup_dst_ports, lookup_src_port}),
    .wr_en       (w_dec_wr),
    .rd_en       (w_dec_rd),
    .dout        (w_dec_dout),
    .full        (w_dec_full),
    .nearly_full (w_dec_nfull),
    .empty       (w_dec_empty),
    .clk         (clk),
    .reset       (reset)
  );

  // The default prune setting only shows while reset holds, when nothing dequeues.
  assign w_prune_en = reset ? PRUNE_SRC_DEFAULT : prune_en;

  opl_mask_prune #(
    .NUM_OUTPUT_QUEUES (NUM_OUTPUT_QUEUES),
    .NUM_IQ_BITS       (NUM_IQ_BITS)
  ) u_mask_prune (
    .i_raw_mask   (w_dec_dout[DEC_W-1 -: NUM_OUTPUT_QUEUES]),
    .i_src_port   (w_dec_dout[NUM_IQ_BITS-1:0]),
    .i_prune_en   (w_prune_en),
    .o_final_mask (w_final_mask),
    .o_mask_zero  (w_mask_zero)
  );

  assign w_head_data = w_pkt_dout[DATA_WIDTH-1:0];
  assign w_head_ctrl = w_pkt_dout[PKT_W-1 -: CTRL_WIDTH];

  assign w_fwd_state = (r_state == ST_HDRS) || (r_state == ST_PAYLOAD);
  assign w_dec_rd    = (r_state == ST_IDLE) && !w_dec_empty && !w_pkt_empty;
  assign w_pkt_rd    = !w_pkt_empty && ((w_fwd_state && out_rdy) || (r_state == ST_DROP));

  always_comb begin
    w_out_data = w_head_data;
    if ((r_state == ST_HDRS) && (w_head_ctrl == IOQ_STAGE_NUM))
      w_out_data[DST_PORT_POS +: NUM_OUTPUT_QUEUES] = r_mask;
  end

  assign out_data = w_out_data;
  assign out_ctrl = w_head_ctrl;
  assign out_wr   = w_fwd_state && out_rdy && !w_pkt_empty;
  assign in_rdy   = !w_pkt_nfull && !w_dec_nfull;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_mask         <= '0;
      r_drop_payload <= 1'b0;
      r_fwd_cnt      <= '0;
      r_drop_cnt     <= '0;
      r_dec_ovf      <= 1'b0;
    end else begin
      if (lookup_valid && w_dec_full) r_dec_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_dec_rd) begin
            r_mask         <= w_final_mask;
            r_drop_payload <= 1'b0;
            r_state        <= w_mask_zero ? ST_DROP : ST_HDRS;
          end
        end
        ST_HDRS: begin
          if (w_pkt_rd && (w_head_ctrl == '0)) r_state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (w_pkt_rd && (w_head_ctrl != '0)) begin
            r_fwd_cnt <= r_fwd_cnt + 32'd1;
            r_state   <= ST_IDLE;
          end
        end
        ST_DROP: begin
          // Same header/payload/EOP tracking as forwarding, without output.
          if (w_pkt_rd) begin
            if (!r_drop_payload) begin
              if (w_head_ctrl == '0) r_drop_payload <= 1'b1;
            end else if (w_head_ctrl != '0) begin
              r_drop_cnt <= r_drop_cnt + 32'd1;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_fwd_cnt  = r_fwd_cnt;
  assign pkt_drop_cnt = r_drop_cnt;
  assign dec_overflow = r_dec_ovf;

endmodule

// File: doc/opl_learning_fwd_stage.md
Name: opl_learning_fwd_stage

Overview:
Forwarding stage of the next-generation learning-switch output port lookup. It buffers packets from the user data path and consumes one lookup decision per packet from an external MAC lookup/learn engine. It writes the final destination-port mask into the IO-queue module header, optionally pruning the ingress port, and silently discards packets whose final mask is empty. Generalised over data width, buffer depths and header format, with per-outcome packet counters.

Parameters:
DATA_WIDTH, 64, data path width in bits
CTRL_WIDTH, DATA_WIDTH/8, ctrl width
NUM_OUTPUT_QUEUES, 8, width of the destination-port mask
NUM_IQ_BITS, 3, width of the ingress-queue index
PKT_FIFO_DEPTH_BITS, 4, log2 depth of the packet word buffer
DEC_FIFO_DEPTH_BITS, 2, log2 depth of the decision buffer
IOQ_STAGE_NUM, 8'hff, ctrl value that marks the IO-queue module header
DST_PORT_POS, 0, LSB of the destination-port field in that header
PRUNE_SRC_DEFAULT, 1, reset value of prune_en

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_data  in  DATA_WIDTH  packet word
in_ctrl  in  CTRL_WIDTH  packet ctrl
in_wr  in  1  word valid
in_rdy  out  1  upstream may write
out_data  out  DATA_WIDTH  packet word
out_ctrl  out  CTRL_WIDTH  packet ctrl
out_wr  out  1  word valid
out_rdy  in  1  downstream may accept
lookup_valid  in  1  one-cycle pulse; decision for next packet
lookup_dst_ports  in  NUM_OUTPUT_QUEUES  raw mask from lookup
lookup_src_port  in  NUM_IQ_BITS  ingress queue index of that packet
prune_en  in  1  clear the ingress bit from the mask
pkt_fwd_cnt  out  32  packets forwarded
pkt_drop_cnt  out  32  packets dropped (empty mask)
dec_overflow  out  1  sticky: decision arrived while decision FIFO full

Behaviour:
- Reset: state IDLE, both FIFOs empty, out_wr=0, counters=0, dec_overflow=0. Reset mid-packet discards all buffered words and decisions.
- in_rdy = !pkt_fifo_nearly_full && !dec_fifo_nearly_full, combinational. Words with in_wr=1 are always written. Nearly-full leaves at least 1 free slot.
- Decision FIFO write on lookup_valid stores {mask, src_port}. Full at write: entry dropped, dec_overflow set until reset.
- Final mask = raw mask with bit lookup_src_port cleared when prune_en=1 (sampled at dequeue). Clearing applies only if src_port < NUM_OUTPUT_QUEUES.
- Decisions pair with packets strictly in arrival order.
- out_data/out_ctrl are driven combinationally from the packet FIFO head (first-word fall-through). out_wr is asserted only with out_rdy=1 and the FIFO non-empty. The FIFO pops in the same cycle.
- FSM:
  - IDLE: when the decision FIFO is non-empty and the packet FIFO is non-empty, pop the decision and latch the final mask. Go to HDRS if the mask != 0, else DROP.
  - HDRS: forward module-header words (ctrl != 0). For a word with ctrl == IOQ_STAGE_NUM, replace out_data[DST_PORT_POS +: NUM_OUTPUT_QUEUES] with the latched mask. The first word with ctrl == 0 is forwarded and the FSM goes to PAYLOAD.
  - PAYLOAD: forward words. The first word with ctrl != 0 is EOP: forward it, increment pkt_fwd_cnt, go to IDLE.
  - DROP: pop one word per cycle regardless of out_rdy, with out_wr=0. Header/payload/EOP are tracked identically. On the EOP pop, increment pkt_drop_cnt and go to IDLE.
- A packet with no IOQ header is forwarded unmodified.
- Counters wrap at 2^32.
- Throughput: 1 word/cycle once a decision is available. Latency from the first buffered word to out_wr is ≥1 cycle after the decision is enqueued.
- Back-to-back packets: IDLE costs 1 bubble cycle per packet.

Decomposition:
- Shared package (op_lut_defines): state encoding (IDLE, HDRS, PAYLOAD, DROP) and the default IOQ_STAGE_NUM/DST_PORT_POS constants.
- Both buffers instantiate the existing small_fifo with their respective depth parameters.
- One natural sub-module: opl_mask_prune, which produces the final mask and zero flag from the raw mask, src_port and prune_en.

Test Plan:
- Header 0xff (ctrl 8'hff), 1 data word, EOP ctrl 8'h80; decision mask 8'h55, src 2, prune_en=1 -> header bits[7:0]=8'h51, words unmodified otherwise, pkt_fwd_cnt=1.
- Same packet, decision mask 8'h04, src 2, prune_en=1 -> no out_wr for any word, pkt_drop_cnt=1, the next packet is forwarded normally.
- prune_en=0, mask 8'h04, src 2 -> header carries 8'h04 and the packet is forwarded.
- Three 8-word packets back-to-back, out_rdy toggling 50% -> all 24 words are output in order, each header has its own mask, pkt_fwd_cnt=3.
- Five decisions pulsed with no packet words -> dec_overflow=1 after the 5th pulse, while 4 decisions remain usable.
- Reset asserted mid-PAYLOAD -> next cycle out_wr=0, counters=0, FIFOs empty, and a fresh packet forwards correctly.
